// File: rtl/fgen_sched_pkg.sv
// fgen_sched_pkg: shared constants for the function generator burst scheduler.
//   - FSM state encodings (IDLE, CONFIG, RUN, DONE)
//   - default burst length / rate divider widths
//   - waveform select encodings understood by the generator
package fgen_sched_pkg;

    localparam int DEF_LEN_W = 16;
    localparam int DEF_DIV_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONFIG = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] SEL_SIN = 2'd0;
    localparam logic [1:0] SEL_COS = 2'd1;
    localparam logic [1:0] SEL_TRI = 2'd2;
    localparam logic [1:0] SEL_SQU = 2'd3;

endpackage

// File: rtl/fgen_rate_div.sv
// fgen_rate_div: sample-rate down-counter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val (has priority over counting)
//   load_val   reload value
//   run        count enable; the counter decrements while non-zero
//   zero       counter is at zero (a sample slot is available)
// At zero the counter simply holds, so a slot blocked downstream is
// deferred rather than lost.
module fgen_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (run && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fgen_burst_sched.sv
// fgen_burst_sched: burst sequencer in front of the function generator.
// Accepts a descriptor {amp, sel, len, div}, pulses the generator config
// strobe for one cycle, then issues samples through the active-low enable
// every (div+1) eligible cycles, stalling while the downstream FIFO is full.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid_i/cfg_ready_o  descriptor handshake
//   cfg_amp_i, cfg_sel_i     amplitude / waveform for the burst
//   cfg_len_i                samples in burst, 0 = continuous
//   cfg_div_i                rate divider
//   abort_i                  end the current burst without done_o
//   fifo_full_i              downstream backpressure
//   gen_en_low_o             generator enable (active low, registered)
//   gen_enh_conf_o           generator configuration strobe
//   gen_amp_o, gen_sel_o     latched amplitude / waveform
//   busy_o, done_o           burst in progress / normal completion pulse
//   sample_cnt_o             samples issued in the current/last burst
//   stall_cnt_o              (FGEN_SCHED_STALL_CNT_EN only) cycles a ready
//                            slot was blocked by fifo_full_i, saturating
// Optional build macro: FGEN_SCHED_STALL_CNT_EN.
module fgen_burst_sched
    import fgen_sched_pkg::*;
#(
    parameter int INT_BITS  = 4,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int RESET_AMP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [INT_BITS-1:0] cfg_amp_i,
    input  logic [1:0]          cfg_sel_i,
    input  logic [LEN_W-1:0]    cfg_len_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    input  logic                abort_i,
    input  logic                fifo_full_i,
    output logic                gen_en_low_o,
    output logic                gen_enh_conf_o,
    output logic [INT_BITS-1:0] gen_amp_o,
    output logic [1:0]          gen_sel_o,
    output logic                busy_o,
    output logic                done_o,
`ifdef FGEN_SCHED_STALL_CNT_EN
    output logic [31:0]         stall_cnt_o,
`endif
    output logic [LEN_W-1:0]    sample_cnt_o
);

    logic [1:0]       state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [DIV_W-1:0] div_q;
    logic             accept, eligible, hit_len, div_zero, issue;

    assign cfg_ready_o = (state == ST_IDLE) && !rst;
    assign accept      = cfg_valid_i && cfg_ready_o;

    // The enable is registered, so the issue decision is taken one cycle
    // ahead: the CONFIG cycle already decides the first sample, which puts
    // it on the generator two cycles after the handshake.
    assign eligible = (state == ST_CONFIG) || (state == ST_RUN);
    assign hit_len  = (len_q != '0) && (sample_cnt_o == len_q);
    assign issue    = eligible && div_zero && !fifo_full_i && !abort_i && !hit_len;

    fgen_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept || issue),
        .load_val (accept ? '0 : div_q),
        .run      (eligible),
        .zero     (div_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_CONFIG;
            ST_CONFIG: state_nxt = abort_i ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort_i)      state_nxt = ST_IDLE;
                else if (hit_len) state_nxt = ST_DONE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            gen_en_low_o   <= 1'b1;
            gen_enh_conf_o <= 1'b0;
            gen_amp_o      <= INT_BITS'(RESET_AMP);
            gen_sel_o      <= SEL_SIN;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            sample_cnt_o   <= '0;
            len_q          <= '0;
            div_q          <= '0;
        end else begin
            state          <= state_nxt;
            gen_en_low_o   <= !issue;
            gen_enh_conf_o <= (state_nxt == ST_CONFIG);
            busy_o         <= (state_nxt == ST_CONFIG) || (state_nxt == ST_RUN);
            done_o         <= (state_nxt == ST_DONE);
            if (accept) begin
                gen_amp_o    <= cfg_amp_i;
                gen_sel_o    <= cfg_sel_i;
                len_q        <= cfg_len_i;
                div_q        <= cfg_div_i;
                sample_cnt_o <= '0;
            end else if (issue) begin
                sample_cnt_o <= sample_cnt_o + 1'b1;
            end
        end
    end

`ifdef FGEN_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (accept)
            stall_cnt_o <= '0;
        else if (state == ST_RUN && div_zero && fifo_full_i && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fgen_burst_sched.sv
// tb_fgen_burst_sched: scoreboard bench. Stimulus pushes the expected
// generator events (config strobe, sample issue, done) with their cycle
// numbers; a negedge monitor pops and compares each event the DUT shows.
module tb_fgen_burst_sched;

    logic        clk, rst;
    logic        cfg_valid_i, cfg_ready_o;
    logic [3:0]  cfg_amp_i;
    logic [1:0]  cfg_sel_i;
    logic [15:0] cfg_len_i, cfg_div_i;
    logic        abort_i, fifo_full_i;
    logic        gen_en_low_o, gen_enh_conf_o, busy_o, done_o;
    logic [3:0]  gen_amp_o;
    logic [1:0]  gen_sel_o;
    logic [15:0] sample_cnt_o;
`ifdef FGEN_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    fgen_burst_sched dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_amp_i      (cfg_amp_i),
        .cfg_sel_i      (cfg_sel_i),
        .cfg_len_i      (cfg_len_i),
        .cfg_div_i      (cfg_div_i),
        .abort_i        (abort_i),
        .fifo_full_i    (fifo_full_i),
        .gen_en_low_o   (gen_en_low_o),
        .gen_enh_conf_o (gen_enh_conf_o),
        .gen_amp_o      (gen_amp_o),
        .gen_sel_o      (gen_sel_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
`ifdef FGEN_SCHED_STALL_CNT_EN
        .stall_cnt_o    (stall_cnt_o),
`endif
        .sample_cnt_o   (sample_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 conf strobe, 1 sample issue, 2 done
        int cyc;
        int cnt;
        int amp;
        int sel;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic void push_ev(input int kind, input int c, input int cnt,
                                    input int amp, input int sel);
        ev_t e;
        e.kind = kind; e.cyc = c; e.cnt = cnt; e.amp = amp; e.sel = sel;
        exp_q.push_back(e);
    endfunction

    // Expected events of an unstalled, unaborted burst accepted in cycle n.
    function automatic void push_burst(input int n, input int len, input int div,
                                       input int amp, input int sel);
        int last;
        push_ev(0, n + 1, 0, amp, sel);
        last = n + 1;
        for (int i = 1; i <= len; i++) begin
            last = n + 2 + (i - 1) * (div + 1);
            push_ev(1, last, i, amp, sel);
        end
        push_ev(2, last + 1, len, amp, sel);
    endfunction

    task automatic mon_one(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d cnt %0d, expected no event",
                     kind, cyc, sample_cnt_o);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.cnt != int'(sample_cnt_o) ||
                e.amp != int'(gen_amp_o) || e.sel != int'(gen_sel_o)) begin
                fails++;
                $display("FAIL event: got kind %0d cyc %0d cnt %0d amp %0d sel %0d, expected kind %0d cyc %0d cnt %0d amp %0d sel %0d",
                         kind, cyc, sample_cnt_o, gen_amp_o, gen_sel_o,
                         e.kind, e.cyc, e.cnt, e.amp, e.sel);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (gen_enh_conf_o) mon_one(0);
            if (!gen_en_low_o)  mon_one(1);
            if (done_o)         mon_one(2);
        end
    end

    // Present a descriptor at a negedge and return the cycle in which the
    // handshake completes; the caller pushes expectations before advancing.
    task automatic send(input logic [3:0] amp, input logic [1:0] sel,
                        input logic [15:0] len, input logic [15:0] div,
                        output int n);
        cfg_valid_i = 1'b1;
        cfg_amp_i = amp; cfg_sel_i = sel; cfg_len_i = len; cfg_div_i = div;
        n = -1;
        for (int i = 0; i < 200; i++) begin
            if (cfg_ready_o) begin
                n = cyc;
                break;
            end
            @(negedge clk);
        end
        if (n < 0) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got no handshake in 200 cycles, expected acceptance");
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en_low"}, gen_en_low_o, 1);
        chk({tag, "_conf"}, gen_enh_conf_o, 0);
        chk({tag, "_amp"}, gen_amp_o, 1);
        chk({tag, "_sel"}, gen_sel_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_cnt"}, sample_cnt_o, 0);
        chk({tag, "_ready"}, cfg_ready_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;
        rst = 1'b1;
        cfg_valid_i = 1'b0; cfg_amp_i = '0; cfg_sel_i = '0;
        cfg_len_i = '0; cfg_div_i = '0; abort_i = 1'b0; fifo_full_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", cfg_ready_o, 1);

        // Basic burst: amp=2 sel=1 len=4 div=0
        send(4'd2, 2'd1, 16'd4, 16'd0, n);
        push_burst(n, 4, 0, 2, 1);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n + 7);
        chk("b1_queue_left", exp_q.size(), 0);
        chk("b1_cnt", sample_cnt_o, 4);
        chk("b1_ready", cfg_ready_o, 1);

        // Divided rate, most-negative amplitude passed through
        send(4'h8, 2'd3, 16'd3, 16'd2, n);
        push_burst(n, 3, 2, 8, 3);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n + 11);
        chk("b2_queue_left", exp_q.size(), 0);
        chk("b2_cnt", sample_cnt_o, 3);

        // FIFO stall after the 2nd issue, amplitude 0
        send(4'd0, 2'd2, 16'd5, 16'd0, n);
        push_ev(0, n + 1, 0, 0, 2);
        push_ev(1, n + 2, 1, 0, 2);
        push_ev(1, n + 3, 2, 0, 2);
        push_ev(1, n + 8, 3, 0, 2);
        push_ev(1, n + 9, 4, 0, 2);
        push_ev(1, n + 10, 5, 0, 2);
        push_ev(2, n + 11, 5, 0, 2);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n + 3); fifo_full_i = 1'b1;
        wait_to(n + 7); fifo_full_i = 1'b0;
        wait_to(n + 13);
        chk("b3_queue_left", exp_q.size(), 0);
        chk("b3_cnt", sample_cnt_o, 5);
`ifdef FGEN_SCHED_STALL_CNT_EN
        chk("b3_stall_cnt", stall_cnt_o, 4);
`endif

        // Continuous mode, abort after 10 issues
        send(4'd7, 2'd0, 16'd0, 16'd1, n);
        push_ev(0, n + 1, 0, 7, 0);
        for (int i = 1; i <= 10; i++) push_ev(1, n + 2 + (i - 1) * 2, i, 7, 0);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n + 20); abort_i = 1'b1;
        wait_to(n + 21); abort_i = 1'b0;
        chk("ab_ready", cfg_ready_o, 1);
        chk("ab_en_low", gen_en_low_o, 1);
        chk("ab_busy", busy_o, 0);
        chk("ab_done", done_o, 0);
        chk("ab_cnt", sample_cnt_o, 10);
        wait_to(n + 25);
        chk("ab_queue_left", exp_q.size(), 0);
        chk("ab_cnt_hold", sample_cnt_o, 10);

        // cfg_valid held through a burst: second accepted after done
        send(4'd3, 2'd1, 16'd2, 16'd0, n);
        push_burst(n, 2, 0, 3, 1);
        @(negedge clk);
        send(4'hF, 2'd2, 16'd1, 16'd0, n2);
        chk("b2b_accept_cycle", n2, n + 5);
        push_burst(n2, 1, 0, 15, 2);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n2 + 5);
        chk("b2b_queue_left", exp_q.size(), 0);
        chk("b2b_cnt", sample_cnt_o, 1);

        // Reset mid-RUN
        send(4'd5, 2'd2, 16'd0, 16'd0, n);
        push_ev(0, n + 1, 0, 5, 2);
        for (int i = 1; i <= 3; i++) push_ev(1, n + 1 + i, i, 5, 2);
        @(negedge clk); cfg_valid_i = 1'b0;
        wait_to(n + 4);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals("mid_rst");
        chk("mid_rst_queue_left", exp_q.size(), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rel_ready", cfg_ready_o, 1);
        chk("mid_rst_rel_amp", gen_amp_o, 1);
        chk("mid_rst_rel_en_low", gen_en_low_o, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
